// File: rtl/i2c_bus_arbiter.sv
// rtl/i2c_bus_arbiter.sv - round-robin arbiter sharing one I2C master between N_REQ requesters
// Grants one register transaction at a time, sequences the master, enforces timeout and bus-idle gap.
module i2c_bus_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int GAP_CYCLES     = 50
) (
  input  logic               clk_ix,
  input  logic               rst_nix,
  input  logic [N_REQ-1:0]   req_ib,
  input  logic [N_REQ-1:0]   rnw_ib,
  input  logic [7*N_REQ-1:0] dev_addr_ib,
  input  logic [8*N_REQ-1:0] reg_addr_ib,
  input  logic [8*N_REQ-1:0] wr_data_ib,
  output logic [N_REQ-1:0]   grant_ob,
  output logic [N_REQ-1:0]   done_ob,
  output logic               error_o,
  output logic [7:0]         rd_data_ob8,
  output logic               m_start_o,
  output logic               m_rnw_o,
  output logic [6:0]         m_dev_addr_ob7,
  output logic [7:0]         m_reg_addr_ob8,
  output logic [7:0]         m_wr_data_ob8,
  output logic               m_abort_o,
  input  logic               m_busy_i,
  input  logic               m_done_i,
  input  logic               m_nack_i,
  input  logic [7:0]         m_rd_data_ib8,
  output logic [15:0]        timeout_cnt_ob16
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_DONE, ST_GAP} state_e;

  state_e           state_q;
  logic [IW-1:0]    ptr_q;
  logic [TW-1:0]    timer_q;
  logic [GW-1:0]    gap_q;
  logic [N_REQ-1:0] grant_q;
  logic [N_REQ-1:0] done_q;
  logic             error_q;
  logic [7:0]       rd_data_q;
  logic             m_start_q;
  logic             m_rnw_q;
  logic [6:0]       m_dev_q;
  logic [7:0]       m_reg_q;
  logic [7:0]       m_wr_q;
  logic             m_abort_q;
  logic [15:0]      tcnt_q;

  logic             found_d;
  logic [IW-1:0]    win_d;
  int               win_idx;

  // busy is informational only; nothing in the sequencing waits on it
  logic unused_busy;
  assign unused_busy = m_busy_i;

  // Walk downward so the request closest above the pointer is the last (winning) assignment.
  always_comb begin
    int idx;
    found_d = 1'b0;
    win_d   = '0;
    idx     = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (req_ib[idx]) begin
        found_d = 1'b1;
        win_d   = IW'(idx);
      end
    end
  end

  assign win_idx = int'(win_d);

  always_ff @(posedge clk_ix or negedge rst_nix) begin
    if (!rst_nix) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      timer_q   <= '0;
      gap_q     <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      error_q   <= 1'b0;
      rd_data_q <= '0;
      m_start_q <= 1'b0;
      m_rnw_q   <= 1'b0;
      m_dev_q   <= '0;
      m_reg_q   <= '0;
      m_wr_q    <= '0;
      m_abort_q <= 1'b0;
      tcnt_q    <= '0;
    end else begin
      m_start_q <= 1'b0;
      m_abort_q <= 1'b0;
      done_q    <= '0;
      error_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (found_d) begin
            grant_q <= N_REQ'(1) << win_d;
            m_rnw_q <= rnw_ib[win_idx];
            m_dev_q <= dev_addr_ib[win_idx*7 +: 7];
            m_reg_q <= reg_addr_ib[win_idx*8 +: 8];
            m_wr_q  <= wr_data_ib[win_idx*8 +: 8];
            ptr_q   <= IW'((win_idx + 1) % N_REQ);
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          m_start_q <= 1'b1;
          timer_q   <= '0;
          state_q   <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          // completion wins over a timeout expiring in the same cycle
          if (m_done_i) begin
            done_q  <= grant_q;
            error_q <= m_nack_i;
            // a NACKed read carries no valid byte, so the previous result is kept
            if (m_rnw_q && !m_nack_i) rd_data_q <= m_rd_data_ib8;
            gap_q   <= '0;
            state_q <= ST_GAP;
          end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            m_abort_q <= 1'b1;
            done_q    <= grant_q;
            error_q   <= 1'b1;
            if (tcnt_q != 16'hFFFF) tcnt_q <= tcnt_q + 16'd1;
            gap_q     <= '0;
            state_q   <= ST_GAP;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_GAP: begin
          // grant stays up through the done cycle, which is the first gap cycle
          grant_q <= '0;
          if (gap_q == GW'(GAP_CYCLES - 1)) state_q <= ST_IDLE;
          else gap_q <= gap_q + GW'(1);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant_ob         = grant_q;
  assign done_ob          = done_q;
  assign error_o          = error_q;
  assign rd_data_ob8      = rd_data_q;
  assign m_start_o        = m_start_q;
  assign m_rnw_o          = m_rnw_q;
  assign m_dev_addr_ob7   = m_dev_q;
  assign m_reg_addr_ob8   = m_reg_q;
  assign m_wr_data_ob8    = m_wr_q;
  assign m_abort_o        = m_abort_q;
  assign timeout_cnt_ob16 = tcnt_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb/tb_i2c_bus_arbiter.sv - self-checking bench for i2c_bus_arbiter
// The bench plays the I2C master and predicts grants, results and counters from the arbitration rules.
module tb_i2c_bus_arbiter;

  localparam int NR  = 4;
  localparam int TMO = 100;
  localparam int GAP = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req, rnw;
  logic [7*NR-1:0] dev;
  logic [8*NR-1:0] regv, wrd;
  logic [NR-1:0] grant_ob, done_ob;
  logic          error_o, m_start_o, m_rnw_o, m_abort_o;
  logic [7:0]    rd_data_ob8, m_reg_addr_ob8, m_wr_data_ob8;
  logic [6:0]    m_dev_addr_ob7;
  logic [15:0]   timeout_cnt_ob16;
  logic          m_busy_i, m_done_i, m_nack_i;
  logic [7:0]    m_rd_data_ib8;

  int            vectors = 0;
  int            miscompares = 0;
  int            ptr_m;
  int            exp_tcnt;
  logic [7:0]    exp_rd;

  always #5 clk = ~clk;

  i2c_bus_arbiter #(.N_REQ(NR), .TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP)) dut (
    .clk_ix(clk), .rst_nix(rst_n), .req_ib(req), .rnw_ib(rnw),
    .dev_addr_ib(dev), .reg_addr_ib(regv), .wr_data_ib(wrd),
    .grant_ob(grant_ob), .done_ob(done_ob), .error_o(error_o), .rd_data_ob8(rd_data_ob8),
    .m_start_o(m_start_o), .m_rnw_o(m_rnw_o), .m_dev_addr_ob7(m_dev_addr_ob7),
    .m_reg_addr_ob8(m_reg_addr_ob8), .m_wr_data_ob8(m_wr_data_ob8), .m_abort_o(m_abort_o),
    .m_busy_i(m_busy_i), .m_done_i(m_done_i), .m_nack_i(m_nack_i),
    .m_rd_data_ib8(m_rd_data_ib8), .timeout_cnt_ob16(timeout_cnt_ob16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NR-1:0] mask, input int p);
    for (int k = 0; k < NR; k++)
      if (mask[(p + k) % NR]) return (p + k) % NR;
    return 0;
  endfunction

  task automatic set_cmd(input int i, input logic r, input logic [6:0] d, input logic [7:0] a,
                         input logic [7:0] w);
    rnw[i] = r;
    dev[i*7 +: 7] = d;
    regv[i*8 +: 8] = a;
    wrd[i*8 +: 8] = w;
  endtask

  task automatic model_reset();
    ptr_m = 0;
    exp_tcnt = 0;
    exp_rd = 8'h00;
    m_busy_i = 1'b0;
    m_done_i = 1'b0;
  endtask

  // One whole transaction: wait for grant, play master, check result; returns in the done cycle.
  task automatic txn(input int lat, input bit nack, input logic [7:0] rdat, input bit tmo,
                     input bit drop, input bit hold, input int exp_polls);
    int w, polls;
    logic [23:0] e_cmd;
    w = rr_pick(req, ptr_m);
    e_cmd = {rnw[w], dev[w*7 +: 7], regv[w*8 +: 8], wrd[w*8 +: 8]};
    polls = 0;
    do begin
      @(negedge clk);
      polls++;
    end while (grant_ob == '0 && polls < 200);
    if (exp_polls > 0) chk("grant_latency", polls, exp_polls);
    chk("grant", grant_ob, 4'b0001 << w);
    ptr_m = (w + 1) % NR;
    chk("cmd_at_grant", {m_rnw_o, m_dev_addr_ob7, m_reg_addr_ob8, m_wr_data_ob8}, e_cmd);
    chk("start_early", m_start_o, 1'b0);
    set_cmd(w, ~rnw[w], 7'($urandom), 8'($urandom), 8'($urandom));
    if (drop) req[w] = 1'b0;
    @(negedge clk);
    chk("start", m_start_o, 1'b1);
    m_busy_i = 1'b1;
    if (!tmo) begin
      for (int k = 0; k < lat; k++) @(negedge clk);
      chk("idle_before_done", {done_ob, error_o, m_abort_o}, '0);
      m_done_i = 1'b1;
      m_nack_i = nack;
      m_rd_data_ib8 = rdat;
      @(negedge clk);
      m_done_i = 1'b0;
      m_nack_i = 1'b0;
      m_busy_i = 1'b0;
      m_rd_data_ib8 = 8'($urandom);
      if (e_cmd[23] && !nack) exp_rd = rdat;
      chk("done", done_ob, 4'b0001 << w);
      chk("error", error_o, nack);
      chk("abort_none", m_abort_o, 1'b0);
    end else begin
      for (int k = 0; k < TMO - 1; k++) @(negedge clk);
      chk("abort_early", {done_ob, m_abort_o}, '0);
      @(negedge clk);
      m_busy_i = 1'b0;
      if (exp_tcnt < 65535) exp_tcnt++;
      chk("abort", m_abort_o, 1'b1);
      chk("done_tmo", done_ob, 4'b0001 << w);
      chk("error_tmo", error_o, 1'b1);
    end
    chk("rd_data", rd_data_ob8, exp_rd);
    chk("tcnt", timeout_cnt_ob16, exp_tcnt);
    chk("grant_at_done", grant_ob, 4'b0001 << w);
    chk("cmd_held", {m_rnw_o, m_dev_addr_ob7, m_reg_addr_ob8, m_wr_data_ob8}, e_cmd);
    if (!hold) req[w] = 1'b0;
  endtask

  initial begin
    int polls;
    rst_n = 1'b0;
    req = '0; rnw = '0; dev = '0; regv = '0; wrd = '0;
    m_nack_i = 1'b0;
    m_rd_data_ib8 = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_grant_done", {grant_ob, done_ob, error_o, m_start_o, m_abort_o}, '0);
    chk("rst_cmd", {m_rnw_o, m_dev_addr_ob7, m_reg_addr_ob8, m_wr_data_ob8}, '0);
    chk("rst_rd_tcnt", {rd_data_ob8, timeout_cnt_ob16}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // single write from idle: grant after 1 cycle, start after 2
    set_cmd(0, 1'b0, 7'h50, 8'h12, 8'hA5);
    req = 4'b0001;
    txn(20, 1'b0, 8'h99, 1'b0, 1'b0, 1'b0, 1);

    // read returning 0x3C, issued back-to-back so the gap is exact
    set_cmd(2, 1'b1, 7'h21, 8'h40, 8'h00);
    req = 4'b0100;
    txn(12, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, GAP + 1);

    // stray master completion during the gap must be ignored
    @(negedge clk);
    m_done_i = 1'b1; m_nack_i = 1'b1; m_rd_data_ib8 = 8'hEE;
    @(negedge clk);
    m_done_i = 1'b0; m_nack_i = 1'b0;
    chk("stray_done", {done_ob, error_o}, '0);
    chk("stray_rd", rd_data_ob8, exp_rd);

    // NACKed read keeps previous rd_data
    set_cmd(1, 1'b1, 7'h33, 8'h07, 8'h00);
    req = 4'b0010;
    txn(7, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 0);

    // timeout, then completion landing exactly on the expiry cycle
    set_cmd(3, 1'b0, 7'h48, 8'h01, 8'h5A);
    req = 4'b1000;
    txn(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, GAP + 1);
    set_cmd(0, 1'b1, 7'h50, 8'h02, 8'h00);
    req = 4'b0001;
    txn(TMO - 1, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, GAP + 1);

    // request dropped right after grant still completes
    set_cmd(1, 1'b0, 7'h10, 8'h20, 8'h30);
    req = 4'b0010;
    txn(5, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, GAP + 1);

    // asynchronous reset while waiting on the master
    set_cmd(2, 1'b0, 7'h2A, 8'h2B, 8'h2C);
    req = 4'b0100;
    polls = 0;
    do begin
      @(negedge clk);
      polls++;
    end while (grant_ob == '0 && polls < 200);
    chk("pre_rst_grant", grant_ob, 4'b0100);
    @(negedge clk);
    chk("pre_rst_start", m_start_o, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs", {grant_ob, m_start_o, done_ob, m_abort_o}, '0);
    chk("mid_rst_tcnt", timeout_cnt_ob16, 16'h0000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    set_cmd(0, 1'b0, 7'h11, 8'h22, 8'h33);
    req = 4'b0101;
    txn(3, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1);
    req = '0;

    // fairness from pointer 0 with all four requests held: 0,1,2,3,0
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < NR; i++) set_cmd(i, 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom));
    req = 4'b1111;
    for (int t = 0; t < 5; t++)
      txn($urandom_range(0, 15), 1'b0, 8'($urandom), 1'b0, 1'b0, 1'b1, (t == 0) ? 1 : GAP + 1);

    // random traffic against the model
    for (int t = 0; t < 14; t++) begin
      logic [NR-1:0] add;
      add = 4'($urandom_range(1, 15));
      for (int i = 0; i < NR; i++)
        if (add[i] && !req[i]) set_cmd(i, 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom));
      req = req | add;
      txn($urandom_range(0, 30), ($urandom_range(0, 3) == 0), 8'($urandom),
          ($urandom_range(0, 6) == 0), 1'($urandom), 1'($urandom), GAP + 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
